// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the VGA sync generator: the 800x600@72 defaults,
// an alternative 640x480@60 set, and the sync polarity encodings.
package vga_timing_pkg;

  localparam bit SYNC_POS = 1'b1;
  localparam bit SYNC_NEG = 1'b0;

  // 800x600@72, 50 MHz pixel rate.
  localparam int SVGA72_H_DISPLAY = 800;
  localparam int SVGA72_H_FRONT   = 56;
  localparam int SVGA72_H_SYNC    = 120;
  localparam int SVGA72_H_BACK    = 64;
  localparam int SVGA72_V_DISPLAY = 600;
  localparam int SVGA72_V_FRONT   = 37;
  localparam int SVGA72_V_SYNC    = 6;
  localparam int SVGA72_V_BACK    = 23;
  localparam int SVGA72_X_W       = 11;
  localparam int SVGA72_Y_W       = 10;

  // 640x480@60, 25.175 MHz pixel rate.
  localparam int VGA60_H_DISPLAY = 640;
  localparam int VGA60_H_FRONT   = 16;
  localparam int VGA60_H_SYNC    = 96;
  localparam int VGA60_H_BACK    = 48;
  localparam int VGA60_V_DISPLAY = 480;
  localparam int VGA60_V_FRONT   = 10;
  localparam int VGA60_V_SYNC    = 2;
  localparam int VGA60_V_BACK    = 33;

  // Minimum counter width able to hold 0..total-1.
  function automatic int count_width(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with clear/advance, plus
// decode of the active window and the sync window for the current count.
module vga_axis_counter #(
  parameter int W       = 11,
  parameter int DISPLAY = 800,
  parameter int FRONT   = 56,
  parameter int SYNC    = 120,
  parameter int BACK    = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         advance,
  output logic [W-1:0] cnt,
  output logic         last,
  output logic         active,
  output logic         sync_act
);

  localparam logic [31:0] TOTAL_M1   = 32'(DISPLAY + FRONT + SYNC + BACK - 1);
  localparam logic [31:0] DISP_U     = 32'(DISPLAY);
  localparam logic [31:0] SYNC_START = 32'(DISPLAY + FRONT);
  localparam logic [31:0] SYNC_END   = 32'(DISPLAY + FRONT + SYNC);

  logic [31:0] cnt_wide;

  // Compare at 32 bits so window edges equal to 2**W cannot alias.
  assign cnt_wide = 32'(cnt);
  assign last     = (cnt_wide == TOTAL_M1);
  assign active   = (cnt_wide < DISP_U);
  assign sync_act = (cnt_wide >= SYNC_START) && (cnt_wide < SYNC_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= last ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync generator driven by a pixel clock-enable.
// Optional line-compare interrupt built only when VGA_TIMING_LINE_IRQ_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = SVGA72_H_DISPLAY,
  parameter int H_FRONT   = SVGA72_H_FRONT,
  parameter int H_SYNC    = SVGA72_H_SYNC,
  parameter int H_BACK    = SVGA72_H_BACK,
  parameter int V_DISPLAY = SVGA72_V_DISPLAY,
  parameter int V_FRONT   = SVGA72_V_FRONT,
  parameter int V_SYNC    = SVGA72_V_SYNC,
  parameter int V_BACK    = SVGA72_V_BACK,
  parameter bit H_POL     = SYNC_POS,
  parameter bit V_POL     = SYNC_POS,
  parameter int X_W       = SVGA72_X_W,
  parameter int Y_W       = SVGA72_Y_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pix_ce,
  input  logic           en,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           line_start,
  output logic           frame_start,
  output logic           vblank_start,
  input  logic [Y_W-1:0] irq_line,
  output logic           line_irq
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  if (H_SYNC == 0 || V_SYNC == 0) begin : g_bad_sync
    $fatal(1, "vga_timing_gen: sync pulse width must be non-zero");
  end
  if (count_width(H_TOTAL) > X_W) begin : g_bad_xw
    $fatal(1, "vga_timing_gen: X_W too narrow for H_TOTAL");
  end
  if (count_width(V_TOTAL) > Y_W) begin : g_bad_yw
    $fatal(1, "vga_timing_gen: Y_W too narrow for V_TOTAL");
  end

  logic           step;
  logic [X_W-1:0] h_cnt;
  logic [Y_W-1:0] v_cnt;
  logic           h_last, h_active, h_sync_act;
  logic           v_wrap_unused, v_active, v_sync_act;
  logic           line_hit;

  assign step     = pix_ce && en;
  assign line_hit = (h_cnt == '0);

  vga_axis_counter #(
    .W(X_W), .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .clear(!en), .advance(step),
    .cnt(h_cnt), .last(h_last), .active(h_active), .sync_act(h_sync_act)
  );

  vga_axis_counter #(
    .W(Y_W), .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .clear(!en), .advance(step && h_last),
    .cnt(v_cnt), .last(v_wrap_unused), .active(v_active), .sync_act(v_sync_act)
  );

  // Outputs sample the counters on each enabled edge, so every output
  // describes the same pixel one pix_ce edge behind the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x            <= '0;
      y            <= '0;
      de           <= 1'b0;
      hsync        <= ~H_POL;
      vsync        <= ~V_POL;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else if (!en) begin
      x            <= '0;
      y            <= '0;
      de           <= 1'b0;
      hsync        <= ~H_POL;
      vsync        <= ~V_POL;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else if (pix_ce) begin
      x            <= h_cnt;
      y            <= v_cnt;
      de           <= h_active && v_active;
      hsync        <= h_sync_act ? H_POL : ~H_POL;
      vsync        <= v_sync_act ? V_POL : ~V_POL;
      line_start   <= line_hit;
      frame_start  <= line_hit && (v_cnt == '0);
      vblank_start <= line_hit && (32'(v_cnt) == 32'(V_DISPLAY));
    end else begin
      // Strobes last one clk only, even when pix_ce stays low.
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_LINE_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_irq <= 1'b0;
    end else if (!en) begin
      line_irq <= 1'b0;
    end else if (pix_ce) begin
      line_irq <= line_hit && (v_cnt == irq_line);
    end else begin
      line_irq <= 1'b0;
    end
  end
`else
  logic irq_line_unused;
  assign irq_line_unused = ^irq_line;
  assign line_irq        = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: small 14x8 timing plus default 800x600 instance.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic de, hs, vs, ls, fs, vb, irq;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic       pix_ce;
  logic       en;
  logic [3:0] irq_line;
  logic       hsync, vsync, de, line_start, frame_start, vblank_start, line_irq;
  logic [3:0] x;
  logic [3:0] y;

  logic        en_d;
  logic [9:0]  irq_line_d;
  logic        d_hsync, d_vsync, d_de, d_ls, d_fs, d_vb, d_irq;
  logic [10:0] d_x;
  logic [9:0]  d_y;

  int   checks = 0;
  int   errors = 0;
  int   m_h, m_v;
  obs_t m_o;
  obs_t exp_q[$];

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_POL(1'b1), .V_POL(1'b1), .X_W(4), .Y_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .en(en),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start), .vblank_start(vblank_start),
    .irq_line(irq_line), .line_irq(line_irq)
  );

  vga_timing_gen dut_def (
    .clk(clk), .rst_n(rst_n), .pix_ce(1'b1), .en(en_d),
    .hsync(d_hsync), .vsync(d_vsync), .de(d_de), .x(d_x), .y(d_y),
    .line_start(d_ls), .frame_start(d_fs), .vblank_start(d_vb),
    .irq_line(irq_line_d), .line_irq(d_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_h = 0;
    m_v = 0;
    m_o = '0;
    exp_q.delete();
  endtask

  // Reference for the small config: H 8/2/3/1, V 4/1/2/1, both polarities high.
  task automatic model_edge(input logic ce, input logic e);
    if (!e) begin
      m_h = 0;
      m_v = 0;
      m_o = '0;
    end else if (ce) begin
      m_o.x  = 4'(m_h);
      m_o.y  = 4'(m_v);
      m_o.de = (m_h < 8) && (m_v < 4);
      m_o.hs = (m_h >= 10) && (m_h <= 12);
      m_o.vs = (m_v == 5) || (m_v == 6);
      m_o.ls = (m_h == 0);
      m_o.fs = (m_h == 0) && (m_v == 0);
      m_o.vb = (m_h == 0) && (m_v == 4);
`ifdef VGA_TIMING_LINE_IRQ_EN
      m_o.irq = (m_h == 0) && (m_v == int'(irq_line));
`else
      m_o.irq = 1'b0;
`endif
      m_h++;
      if (m_h == 14) begin
        m_h = 0;
        m_v++;
        if (m_v == 8) m_v = 0;
      end
    end else begin
      m_o.ls  = 1'b0;
      m_o.fs  = 1'b0;
      m_o.vb  = 1'b0;
      m_o.irq = 1'b0;
    end
    exp_q.push_back(m_o);
  endtask

  task automatic cycle(input logic ce, input logic e);
    pix_ce = ce;
    en     = e;
    model_edge(ce, e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic take(output obs_t got, output obs_t e);
    got = {x, y, de, hsync, vsync, line_start, frame_start, vblank_start, line_irq};
    if (exp_q.size() == 0) e = 'x;
    else e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    obs_t got, e;
    rst_n = 1'b0; pix_ce = 1'b1; en = 1'b1;
    repeat (3) @(negedge clk);
    got = {x, y, de, hsync, vsync, line_start, frame_start, vblank_start, line_irq};
    checks++;
    if (got !== obs_t'('0)) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", got, obs_t'('0));
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1);
      take(got, e);
      checks++;
      if (got !== e) begin
        errors++; $display("FAIL reset_run i=%0d got=%h exp=%h", i, got, e);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({x, y, hsync, de} !== 10'b0) begin
      errors++; $display("FAIL async_reset x=%0d y=%0d hs=%b de=%b exp 0", x, y, hsync, de);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b1);
    take(got, e);
    checks++;
    if (got !== e || got.fs !== 1'b1 || got.x !== 4'd0 || got.y !== 4'd0) begin
      errors++; $display("FAIL reset_first_edge got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_full_frame();
    obs_t got, e;
    int first_fs = -1, second_fs = -1, de_cnt = 0, vs_cnt = 0, max_x = 0, max_y = 0;
    for (int i = 0; i < 240; i++) begin
      cycle(1'b1, 1'b1);
      take(got, e);
      checks++;
      if (got !== e) begin
        errors++; $display("FAIL frame i=%0d got=%h exp=%h", i, got, e);
      end
      if (got.fs) begin
        if (first_fs < 0) first_fs = i;
        else if (second_fs < 0) second_fs = i;
      end
      if (first_fs >= 0 && second_fs < 0) begin
        if (got.de) de_cnt++;
        if (got.vs) vs_cnt++;
      end
      if (int'(got.x) > max_x) max_x = int'(got.x);
      if (int'(got.y) > max_y) max_y = int'(got.y);
    end
    checks++;
    if (second_fs - first_fs != 112) begin
      errors++; $display("FAIL frame_period got=%0d exp=112", second_fs - first_fs);
    end
    checks++;
    if (de_cnt != 32) begin
      errors++; $display("FAIL de_count got=%0d exp=32", de_cnt);
    end
    checks++;
    if (vs_cnt != 28) begin
      errors++; $display("FAIL vsync_count got=%0d exp=28", vs_cnt);
    end
    checks++;
    if (max_x != 13 || max_y != 7) begin
      errors++; $display("FAIL coord_max got x=%0d y=%0d exp x=13 y=7", max_x, max_y);
    end
  endtask

  task automatic test_ce_third();
    obs_t got, e;
    int first_fs = -1, second_fs = -1, ls_cnt = 0, vb_cnt = 0;
    for (int i = 0; i < 1100; i++) begin
      cycle((i % 3) == 0, 1'b1);
      take(got, e);
      checks++;
      if (got !== e) begin
        errors++; $display("FAIL ce3 i=%0d got=%h exp=%h", i, got, e);
      end
      if (got.fs) begin
        if (first_fs < 0) first_fs = i;
        else if (second_fs < 0) second_fs = i;
      end
      if (first_fs >= 0 && second_fs < 0) begin
        if (got.ls) ls_cnt++;
        if (got.vb) vb_cnt++;
      end
    end
    checks++;
    if (second_fs - first_fs != 336) begin
      errors++; $display("FAIL ce3_period got=%0d exp=336", second_fs - first_fs);
    end
    checks++;
    if (ls_cnt != 8 || vb_cnt != 1) begin
      errors++; $display("FAIL ce3_strobes got ls=%0d vb=%0d exp ls=8 vb=1", ls_cnt, vb_cnt);
    end
  endtask

  task automatic test_en_drop();
    obs_t got, e;
    bit found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      cycle(1'b1, 1'b1);
      take(got, e);
      checks++;
      if (got !== e) begin
        errors++; $display("FAIL en_seek i=%0d got=%h exp=%h", i, got, e);
      end
      if (got.y == 4'd3 && got.x == 4'd7) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL en_seek_timeout got no y=3 x=7 exp found");
    end
    for (int i = 0; i < 6; i++) begin
      cycle((i % 2) == 0, 1'b0);
      take(got, e);
      checks++;
      if (got !== e || got !== obs_t'('0)) begin
        errors++; $display("FAIL en_idle i=%0d got=%h exp=%h", i, got, e);
      end
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1);
      take(got, e);
      checks++;
      if (got !== e) begin
        errors++; $display("FAIL en_wait i=%0d got=%h exp=%h", i, got, e);
      end
    end
    cycle(1'b1, 1'b1);
    take(got, e);
    checks++;
    if (got !== e || got.fs !== 1'b1 || got.x !== 4'd0 || got.y !== 4'd0) begin
      errors++; $display("FAIL en_restart got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_line_irq();
    obs_t got, e;
    int irq_cnt = 0;
`ifdef VGA_TIMING_LINE_IRQ_EN
    irq_line = 4'd6;
    for (int i = 0; i < 112; i++) begin
      cycle(1'b1, 1'b1);
      take(got, e);
      checks++;
      if (got !== e) begin
        errors++; $display("FAIL irq6 i=%0d got=%h exp=%h", i, got, e);
      end
      if (got.irq) irq_cnt++;
    end
    checks++;
    if (irq_cnt != 1) begin
      errors++; $display("FAIL irq6_count got=%0d exp=1", irq_cnt);
    end
    irq_line = 4'd9;
    irq_cnt = 0;
`endif
    for (int i = 0; i < 112; i++) begin
      cycle(1'b1, 1'b1);
      take(got, e);
      checks++;
      if (got !== e) begin
        errors++; $display("FAIL irq_off i=%0d got=%h exp=%h", i, got, e);
      end
      if (got.irq) irq_cnt++;
    end
    checks++;
    if (irq_cnt != 0) begin
      errors++; $display("FAIL irq_off_count got=%0d exp=0", irq_cnt);
    end
  endtask

  task automatic test_default();
    int rise[3];
    int n_rise = 0;
    logic prev_hs;
    en = 1'b0;
    pix_ce = 1'b0;
    en_d = 1'b1;
    prev_hs = d_hsync;
    for (int i = 0; i < 5000 && n_rise < 3; i++) begin
      @(negedge clk);
      if (d_hsync && !prev_hs) begin
        rise[n_rise] = i;
        n_rise++;
      end
      prev_hs = d_hsync;
    end
    checks++;
    if (n_rise != 3) begin
      errors++; $display("FAIL def_hsync_rises got=%0d exp=3", n_rise);
    end else begin
      checks++;
      if (rise[1] - rise[0] != 1040 || rise[2] - rise[1] != 1040) begin
        errors++; $display("FAIL def_hsync_spacing got=%0d,%0d exp=1040", rise[1] - rise[0], rise[2] - rise[1]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; pix_ce = 1'b0; en = 1'b0; irq_line = 4'd0;
    en_d = 1'b0; irq_line_d = 10'd0;
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_ce_third();
    test_en_drop();
    test_line_irq();
    test_default();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
